// File: rtl/branch_predictor.sv
// Front-end branch predictor: direct-mapped BTB with 2-bit counters, commit-time RAS,
// and resolution-side mispredict/branch statistics.
module branch_predictor #(
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [2:0]  pred_type,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [2:0]  upd_type,
  input  logic        upd_pre_taken,
  input  logic [31:0] upd_pre_target,
  input  logic        upd_true_taken,
  input  logic [31:0] upd_true_target,
  output logic        mispredict,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 32 - IW - 2;
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

  localparam logic [2:0] T_BR   = 3'd1;
  localparam logic [2:0] T_JAL  = 3'd2;
  localparam logic [2:0] T_JALR = 3'd3;
  localparam logic [2:0] T_CALL = 3'd4;
  localparam logic [2:0] T_RET  = 3'd5;

  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
  logic [2:0]             btb_type   [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];

  logic [31:0] ras     [RAS_DEPTH];
  logic [RW-1:0] ras_ptr;  // next slot to write; top of stack is ras_ptr-1
  logic [RW:0]   ras_cnt;

  logic [IW-1:0] p_idx, u_idx;
  logic [TW-1:0] p_tag, u_tag;
  logic          p_hit, u_hit, u_acc, u_mis;
  logic [31:0]   ras_top;

  assign p_idx   = pred_pc[IW+1:2];
  assign p_tag   = pred_pc[31:IW+2];
  assign p_hit   = btb_vld[p_idx] && (btb_tag[p_idx] == p_tag);
  assign u_idx   = upd_pc[IW+1:2];
  assign u_tag   = upd_pc[31:IW+2];
  assign u_hit   = btb_vld[u_idx] && (btb_tag[u_idx] == u_tag);
  assign u_acc   = upd_valid && (upd_type >= T_BR) && (upd_type <= T_RET);
  assign u_mis   = (upd_pre_taken != upd_true_taken) ||
                   (upd_true_taken && (upd_pre_target != upd_true_target));
  assign ras_top = ras[ras_ptr - 1'b1];

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    pred_type   = 3'd0;
    if (pred_valid) begin
      pred_target = pred_pc + 32'd4;
      if (p_hit) begin
        pred_type = btb_type[p_idx];
        case (btb_type[p_idx])
          T_BR: begin
            if (btb_ctr[p_idx][1]) begin
              pred_taken  = 1'b1;
              pred_target = btb_target[p_idx];
            end
          end
          T_JAL, T_JALR, T_CALL: begin
            pred_taken  = 1'b1;
            pred_target = btb_target[p_idx];
          end
          T_RET: begin
            pred_taken  = 1'b1;
            pred_target = (ras_cnt != '0) ? ras_top : btb_target[p_idx];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld    <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_type[i]   <= '0;
        btb_ctr[i]    <= '0;
        btb_target[i] <= '0;
      end
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      ras_ptr    <= '0;
      ras_cnt    <= '0;
      mispredict <= 1'b0;
      br_cnt     <= '0;
      miss_cnt   <= '0;
    end else begin
      mispredict <= u_acc && u_mis;
      if (u_acc) begin
        br_cnt <= br_cnt + 32'd1;
        if (u_mis) miss_cnt <= miss_cnt + 32'd1;

        if (u_hit) begin
          if (upd_type == T_BR) begin
            if (upd_true_taken && btb_ctr[u_idx] != 2'b11)
              btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'd1;
            else if (!upd_true_taken && btb_ctr[u_idx] != 2'b00)
              btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'd1;
          end
          if (upd_true_taken) btb_target[u_idx] <= upd_true_target;
          btb_type[u_idx] <= upd_type;
        end else if (upd_true_taken || upd_type != T_BR) begin
          btb_vld[u_idx]    <= 1'b1;
          btb_tag[u_idx]    <= u_tag;
          btb_type[u_idx]   <= upd_type;
          btb_target[u_idx] <= upd_true_target;
          btb_ctr[u_idx]    <= (upd_type == T_BR) ? 2'b10 : 2'b11;
        end

        // Full stack overwrites the oldest entry by letting the pointer wrap.
        if (upd_type == T_CALL) begin
          ras[ras_ptr] <= upd_pc + 32'd4;
          ras_ptr      <= ras_ptr + 1'b1;
          if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
        end else if (upd_type == T_RET && ras_cnt != '0) begin
          ras_ptr <= ras_ptr - 1'b1;
          ras_cnt <= ras_cnt - 1'b1;
        end
      end
    end
  end
endmodule
